// File: rtl/op_dispatch_if.sv
// Opcode dispatch bundle: host handshake, unit select/done and status.
// Master drives opcode and unit done strobes; slave is the dispatcher.
interface op_dispatch_if #(
  parameter int OP_W    = 4,
  parameter int NUM_OPS = 16
);
  logic               op_valid;
  logic               op_ready;
  logic [OP_W-1:0]    op_code;
  logic [NUM_OPS-1:0] hotselect;
  logic [NUM_OPS-1:0] unit_done;
  logic               cmd_done;
  logic               cmd_err;
  logic               busy;

  modport master (
    output op_valid, op_code, unit_done,
    input  op_ready, hotselect, cmd_done, cmd_err, busy
  );

  modport slave (
    input  op_valid, op_code, unit_done,
    output op_ready, hotselect, cmd_done, cmd_err, busy
  );
endinterface

// File: rtl/op_dispatch_decoder.sv
// Registered opcode decoder/dispatcher with one-hot unit select.
// Optional WAIT timeout enabled by defining DISPATCH_TIMEOUT_EN.
module op_dispatch_decoder #(
  parameter int OP_W    = 4,
  parameter int NUM_OPS = 16,
  parameter int TMO_CYC = 255
) (
  input logic         clk,
  input logic         reset,
  op_dispatch_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [OP_W:0] N_L = (OP_W+1)'(NUM_OPS);

  state_t             state_q, state_d;
  logic [NUM_OPS-1:0] sel_q, sel_d;
  logic               err_q, err_d;
  logic               hit;
  logic               tmo;

  // only the currently selected unit can complete the command
  assign hit = |(bus.unit_done & sel_q);

`ifdef DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q != S_WAIT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // count reaches TMO_CYC on this edge
  assign tmo = (state_q == S_WAIT) &&
               (cnt_q == CNT_W'(TMO_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (bus.op_valid) begin
          if ({1'b0, bus.op_code} < N_L) begin
            sel_d   = NUM_OPS'(1) << bus.op_code;
            state_d = S_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (hit) begin
          sel_d   = '0;
          state_d = S_DONE;
        end else if (tmo) begin
          sel_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign bus.hotselect = sel_q;
  assign bus.op_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.cmd_done  = (state_q == S_DONE);
  assign bus.cmd_err   = (state_q == S_DONE) & err_q;
endmodule

// File: tb/tb_op_dispatch_decoder.sv
// Directed bench for op_dispatch_decoder with an expected-result queue.
// Timeout cases run when DISPATCH_TIMEOUT_EN is defined.
module tb_op_dispatch_decoder;
  localparam int OP_W    = 4;
  localparam int NUM_OPS = 10;
  localparam int TMO     = 8;

  typedef struct {
    logic [NUM_OPS-1:0] sel;
    logic               err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  op_dispatch_if #(.OP_W(OP_W), .NUM_OPS(NUM_OPS)) bus ();

  op_dispatch_decoder #(
    .OP_W(OP_W), .NUM_OPS(NUM_OPS), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int op);
    exp_t e;
    e.sel = (op < NUM_OPS) ? (NUM_OPS'(1) << op) : '0;
    e.err = (op >= NUM_OPS);
    return e;
  endfunction

  task automatic issue(input string tag, input int op);
    int n;
    n = 0;
    while (bus.op_ready !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.op_ready), 32'd1);
    bus.op_valid = 1'b1;
    bus.op_code  = op[OP_W-1:0];
    sb.push_back(model(op));
    step;
    bus.op_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (bus.cmd_done !== 1'b1 && n < budget) begin
      step;
      n++;
    end
    chk({tag, "_done"}, 32'(bus.cmd_done), 32'd1);
    chk({tag, "_hot0"}, 32'(bus.hotselect), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err"}, 32'(bus.cmd_err), 32'(e.err));
    end
    step;
    chk({tag, "_pulse"}, 32'(bus.cmd_done), 32'd0);
  endtask

  initial begin
    int   seen;
    exp_t e;
    bus.op_valid  = 1'b0;
    bus.op_code   = '0;
    bus.unit_done = '0;
    #12;
    chk("rst_hot", 32'(bus.hotselect), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.cmd_done), 32'd0);
    chk("rst_err", 32'(bus.cmd_err), 32'd0);
    reset = 1'b0;
    step;
    chk("rst_ready", 32'(bus.op_ready), 32'd1);

    // reset in the middle of a WAIT
    issue("mid", 5);
    chk("mid_hot", 32'(bus.hotselect), 32'h20);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_hot", 32'(bus.hotselect), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.cmd_done), 32'd0);
    sb.delete();
    step;
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      step;
      if (bus.cmd_done === 1'b1) seen++;
    end
    chk("mid_no_done", 32'(seen), 32'd0);

    // full sweep, upper codes illegal
    for (int op = 0; op < 16; op++) begin
      issue($sformatf("sw%0d", op), op);
      e = sb[0];
      chk($sformatf("sw%0d_hot", op), 32'(bus.hotselect), 32'(e.sel));
      if (op < NUM_OPS) begin
        step;
        step;
        chk($sformatf("sw%0d_hold", op), 32'(bus.hotselect),
            32'(e.sel));
        bus.unit_done = NUM_OPS'(1) << op;
        step;
        bus.unit_done = '0;
        finish_cmd($sformatf("sw%0d", op), 0);
      end else begin
        finish_cmd($sformatf("sw%0d", op), 3);
      end
    end

    // done from a different unit is ignored
    issue("wu", 3);
    bus.unit_done = NUM_OPS'(1) << 7;
    step;
    step;
    chk("wu_hot", 32'(bus.hotselect), 32'h8);
    chk("wu_nodone", 32'(bus.cmd_done), 32'd0);
    bus.unit_done = NUM_OPS'(1) << 3;
    step;
    bus.unit_done = '0;
    finish_cmd("wu", 0);

    // back-to-back with op_valid held and done already high
    bus.unit_done = '1;
    bus.op_valid  = 1'b1;
    bus.op_code   = 4'd1;
    sb.push_back(model(1));
    step;
    chk("bb_hot1", 32'(bus.hotselect), 32'h2);
    bus.op_code = 4'd2;
    sb.push_back(model(2));
    step;
    chk("bb_done1", 32'(bus.cmd_done), 32'd1);
    chk("bb_gap_hot", 32'(bus.hotselect), 32'd0);
    e = sb.pop_front();
    chk("bb_err1", 32'(bus.cmd_err), 32'(e.err));
    step;
    chk("bb_idle_ready", 32'(bus.op_ready), 32'd1);
    chk("bb_idle_hot", 32'(bus.hotselect), 32'd0);
    step;
    bus.op_valid = 1'b0;
    chk("bb_hot2", 32'(bus.hotselect), 32'h4);
    step;
    chk("bb_done2", 32'(bus.cmd_done), 32'd1);
    e = sb.pop_front();
    chk("bb_err2", 32'(bus.cmd_err), 32'(e.err));
    bus.unit_done = '0;
    step;

`ifdef DISPATCH_TIMEOUT_EN
    issue("tmo", 4);
    seen = 0;
    while (bus.cmd_done !== 1'b1 && seen < 20) begin
      step;
      seen++;
    end
    chk("tmo_lat", 32'(seen), 32'(TMO));
    chk("tmo_done", 32'(bus.cmd_done), 32'd1);
    e = sb.pop_front();
    chk("tmo_err", 32'(bus.cmd_err), 32'(e.err | 1'b1));
    step;
    issue("tmo_edge", 4);
    repeat (TMO - 1) step;
    bus.unit_done = NUM_OPS'(1) << 4;
    step;
    bus.unit_done = '0;
    finish_cmd("tmo_edge", 0);
`else
    issue("notmo", 6);
    seen = 0;
    repeat (300) begin
      step;
      if (bus.cmd_done === 1'b1 || bus.hotselect !== 10'h040) seen++;
    end
    chk("notmo_hold", 32'(seen), 32'd0);
    bus.unit_done = NUM_OPS'(1) << 6;
    step;
    bus.unit_done = '0;
    finish_cmd("notmo", 0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
